// File: rtl/cndm_irq_pkg.sv
// rtl/cndm_irq_pkg.sv - shared types and constants for the cndm MSI interrupt controller
package cndm_irq_pkg;

    localparam int MAX_MSI_VEC = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        BACKOFF
    } irq_state_t;

    // The hard block may report up to 7 in mmenable; only 32 vectors exist.
    function automatic logic [2:0] clamp_mme(input logic [2:0] mme);
        return (mme > 3'd5) ? 3'd5 : mme;
    endfunction

endpackage

// File: rtl/cndm_irq_msi_if.sv
// rtl/cndm_irq_msi_if.sv - request stream and cfg_interrupt_msi bundle
interface cndm_irq_msi_if #(
    parameter int IRQ_CNT = 32
) ();
    localparam int IDX_W = (IRQ_CNT > 1) ? $clog2(IRQ_CNT) : 1;

    logic             s_irq_valid;
    logic [IDX_W-1:0] s_irq_index;
    logic             s_irq_ready;

    logic [3:0]       cfg_interrupt_msi_enable;
    logic [11:0]      cfg_interrupt_msi_mmenable;
    logic             cfg_interrupt_msi_mask_update;
    logic [31:0]      cfg_interrupt_msi_data;
    logic [1:0]       cfg_interrupt_msi_select;
    logic [31:0]      cfg_interrupt_msi_int;
    logic [31:0]      cfg_interrupt_msi_pending_status;
    logic             cfg_interrupt_msi_pending_status_data_enable;
    logic [1:0]       cfg_interrupt_msi_pending_status_function_num;
    logic             cfg_interrupt_msi_sent;
    logic             cfg_interrupt_msi_fail;
    logic [2:0]       cfg_interrupt_msi_attr;
    logic             cfg_interrupt_msi_tph_present;
    logic [1:0]       cfg_interrupt_msi_tph_type;
    logic [7:0]       cfg_interrupt_msi_tph_st_tag;
    logic [7:0]       cfg_interrupt_msi_function_number;

    // Controller side
    modport slave (
        input  s_irq_valid, s_irq_index,
        output s_irq_ready,
        input  cfg_interrupt_msi_enable, cfg_interrupt_msi_mmenable,
        input  cfg_interrupt_msi_mask_update, cfg_interrupt_msi_data,
        input  cfg_interrupt_msi_sent, cfg_interrupt_msi_fail,
        output cfg_interrupt_msi_select, cfg_interrupt_msi_int,
        output cfg_interrupt_msi_pending_status,
        output cfg_interrupt_msi_pending_status_data_enable,
        output cfg_interrupt_msi_pending_status_function_num,
        output cfg_interrupt_msi_attr, cfg_interrupt_msi_tph_present,
        output cfg_interrupt_msi_tph_type, cfg_interrupt_msi_tph_st_tag,
        output cfg_interrupt_msi_function_number
    );

    // Event source and PCIe hard block side
    modport master (
        output s_irq_valid, s_irq_index,
        input  s_irq_ready,
        output cfg_interrupt_msi_enable, cfg_interrupt_msi_mmenable,
        output cfg_interrupt_msi_mask_update, cfg_interrupt_msi_data,
        output cfg_interrupt_msi_sent, cfg_interrupt_msi_fail,
        input  cfg_interrupt_msi_select, cfg_interrupt_msi_int,
        input  cfg_interrupt_msi_pending_status,
        input  cfg_interrupt_msi_pending_status_data_enable,
        input  cfg_interrupt_msi_pending_status_function_num,
        input  cfg_interrupt_msi_attr, cfg_interrupt_msi_tph_present,
        input  cfg_interrupt_msi_tph_type, cfg_interrupt_msi_tph_st_tag,
        input  cfg_interrupt_msi_function_number
    );

endinterface

// File: rtl/cndm_irq_rr_arb.sv
// rtl/cndm_irq_rr_arb.sv - combinational round-robin priority encoder
module cndm_irq_rr_arb #(
    parameter int N     = 32,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             valid
);

    // Scan from last+1 upward, wrapping, and take the first requester.
    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        idx       = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!valid && req[idx]) begin
                valid      = 1'b1;
                grant_idx  = IDX_W'(idx);
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cndm_irq_msi.sv
// rtl/cndm_irq_msi.sv - multi-vector MSI controller with mask, holdoff and retry
module cndm_irq_msi
    import cndm_irq_pkg::*;
#(
    parameter int IRQ_CNT      = 32,
    parameter int HOLDOFF_W    = 16,
    parameter int TICK_DIV     = 250,
    parameter int RETRY_DELAY  = 64,
    parameter int WAIT_TIMEOUT = 1024
) (
    input  logic                 pcie_clk,
    input  logic                 pcie_rst,
    cndm_irq_msi_if.slave        irq,
    input  logic [HOLDOFF_W-1:0] cfg_holdoff,
    output logic [15:0]          stat_fail_count
);

    localparam int IDX_W  = (IRQ_CNT > 1) ? $clog2(IRQ_CNT) : 1;
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CNT_W  = $clog2((RETRY_DELAY > WAIT_TIMEOUT) ? RETRY_DELAY : WAIT_TIMEOUT) + 1;

    irq_state_t             state;
    logic                   ready_q;
    logic [IRQ_CNT-1:0]     pending, pending_nxt;
    logic                   pend_de;
    logic [MAX_MSI_VEC-1:0] mask;
    logic [HOLDOFF_W-1:0]   holdoff [IRQ_CNT];
    logic [IRQ_CNT-1:0]     hold_zero;
    logic [TICK_W-1:0]      presc;
    logic                   tick;
    logic [CNT_W-1:0]       cnt;
    logic [IDX_W-1:0]       cur_vec, last_idx, folded, idx_mask;
    logic [MAX_MSI_VEC-1:0] msi_int, granted;
    logic [15:0]            fail_cnt;
    logic [2:0]             mme;
    logic [IRQ_CNT-1:0]     elig, grant;
    logic [IDX_W-1:0]       grant_idx;
    logic                   grant_valid;
    logic                   req_fire, wait_sent, wait_fail;
    logic                   unused_cfg;

    assign mme      = clamp_mme(irq.cfg_interrupt_msi_mmenable[2:0]);
    assign idx_mask = IDX_W'((32'd1 << mme) - 32'd1);
    assign granted  = ~({MAX_MSI_VEC{1'b1}} << (6'd1 << mme));
    assign folded   = irq.s_irq_index & idx_mask;
    assign req_fire = irq.s_irq_valid & ready_q;
    assign tick     = (presc == TICK_W'(TICK_DIV - 1));

    assign wait_sent = (state == WAIT) && irq.cfg_interrupt_msi_sent;
    assign wait_fail = (state == WAIT) && !irq.cfg_interrupt_msi_sent &&
                       (irq.cfg_interrupt_msi_fail || cnt == CNT_W'(WAIT_TIMEOUT - 1));

    // A vector is a candidate only when pending, unmasked and out of holdoff.
    always_comb begin
        for (int i = 0; i < IRQ_CNT; i++) begin
            hold_zero[i] = (holdoff[i] == '0);
        end
        elig = pending & ~mask[IRQ_CNT-1:0] & hold_zero &
               {IRQ_CNT{irq.cfg_interrupt_msi_enable[0]}};
    end

    cndm_irq_rr_arb #(
        .N     (IRQ_CNT),
        .IDX_W (IDX_W)
    ) u_arb (
        .req       (elig),
        .last      (last_idx),
        .grant     (grant),
        .grant_idx (grant_idx),
        .valid     (grant_valid)
    );

    // Next pending: issue clears, then retry restore and new requests set.
    always_comb begin
        pending_nxt = pending;
        if (state == IDLE && grant_valid) begin
            pending_nxt[grant_idx] = 1'b0;
        end
        if (wait_fail) begin
            pending_nxt[cur_vec] = 1'b1;
        end
        if (req_fire) begin
            pending_nxt[folded] = 1'b1;
        end
    end

    // Pending bitmap, change strobe, request-ready and host mask registers.
    always_ff @(posedge pcie_clk) begin
        if (pcie_rst) begin
            pending <= '0;
            pend_de <= 1'b0;
            ready_q <= 1'b0;
            mask    <= '0;
        end else begin
            pending <= pending_nxt;
            pend_de <= (pending_nxt != pending);
            ready_q <= 1'b1;
            if (irq.cfg_interrupt_msi_mask_update) begin
                mask <= irq.cfg_interrupt_msi_data;
            end
        end
    end

    // Free-running holdoff tick prescaler.
    always_ff @(posedge pcie_clk) begin
        if (pcie_rst) begin
            presc <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
        end
    end

    // Per-vector holdoff: reload on successful send, count down on ticks.
    always_ff @(posedge pcie_clk) begin
        if (pcie_rst) begin
            for (int i = 0; i < IRQ_CNT; i++) begin
                holdoff[i] <= '0;
            end
        end else begin
            for (int i = 0; i < IRQ_CNT; i++) begin
                if (wait_sent && cur_vec == IDX_W'(i)) begin
                    holdoff[i] <= cfg_holdoff;
                end else if (tick && holdoff[i] != '0) begin
                    holdoff[i] <= holdoff[i] - 1'b1;
                end
            end
        end
    end

    // Issue FSM: pulse msi_int, await sent/fail, back off before retrying.
    always_ff @(posedge pcie_clk) begin
        if (pcie_rst) begin
            state    <= IDLE;
            msi_int  <= '0;
            cur_vec  <= '0;
            last_idx <= IDX_W'(IRQ_CNT - 1);
            cnt      <= '0;
            fail_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        msi_int  <= MAX_MSI_VEC'(grant);
                        cur_vec  <= grant_idx;
                        last_idx <= grant_idx;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    msi_int <= '0;
                    cnt     <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (wait_sent) begin
                        state <= IDLE;
                    end else if (wait_fail) begin
                        if (fail_cnt != 16'hFFFF) begin
                            fail_cnt <= fail_cnt + 16'd1;
                        end
                        cnt   <= '0;
                        state <= BACKOFF;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BACKOFF: begin
                    if (cnt == CNT_W'(RETRY_DELAY - 1)) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign irq.s_irq_ready                                  = ready_q;
    assign irq.cfg_interrupt_msi_int                        = msi_int;
    assign irq.cfg_interrupt_msi_pending_status             = MAX_MSI_VEC'(pending) & granted;
    assign irq.cfg_interrupt_msi_pending_status_data_enable = pend_de;
    assign irq.cfg_interrupt_msi_select                     = 2'd0;
    assign irq.cfg_interrupt_msi_pending_status_function_num = 2'd0;
    assign irq.cfg_interrupt_msi_attr                       = 3'd0;
    assign irq.cfg_interrupt_msi_tph_present                = 1'b0;
    assign irq.cfg_interrupt_msi_tph_type                   = 2'd0;
    assign irq.cfg_interrupt_msi_tph_st_tag                 = 8'd0;
    assign irq.cfg_interrupt_msi_function_number            = 8'd0;
    assign stat_fail_count                                  = fail_cnt;

    // Only function 0 and the low three mmenable bits matter here.
    assign unused_cfg = ^{irq.cfg_interrupt_msi_enable[3:1], irq.cfg_interrupt_msi_mmenable[11:3]};

endmodule

// File: tb/tb_cndm_irq_msi.sv
// tb/tb_cndm_irq_msi.sv - directed self-checking bench for cndm_irq_msi
module tb_cndm_irq_msi;

    logic        pcie_clk = 1'b0;
    logic        pcie_rst = 1'b1;
    logic [15:0] cfg_holdoff;
    logic [15:0] stat_fail_count;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          k;
    logic [31:0] v;

    cndm_irq_msi_if #(.IRQ_CNT(32)) bus ();

    cndm_irq_msi #(
        .IRQ_CNT      (32),
        .HOLDOFF_W    (16),
        .TICK_DIV     (4),
        .RETRY_DELAY  (64),
        .WAIT_TIMEOUT (1024)
    ) dut (
        .pcie_clk        (pcie_clk),
        .pcie_rst        (pcie_rst),
        .irq             (bus),
        .cfg_holdoff     (cfg_holdoff),
        .stat_fail_count (stat_fail_count)
    );

    always #5 pcie_clk = ~pcie_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge pcie_clk);
        #1;
    endtask

    task automatic send_irq(input int idx);
        bus.s_irq_valid = 1'b1;
        bus.s_irq_index = 5'(idx);
        step();
        bus.s_irq_valid = 1'b0;
    endtask

    task automatic wait_int(input string tag, input int budget, output int cycles, output logic [31:0] val);
        cycles = 0;
        val    = '0;
        while (cycles < budget && bus.cfg_interrupt_msi_int == 32'd0) begin
            step();
            cycles++;
        end
        val = bus.cfg_interrupt_msi_int;
        if (val == 32'd0) chk({tag, "_seen"}, 32'(bus.cfg_interrupt_msi_int != 0), 32'd1);
    endtask

    task automatic pulse_sent();
        bus.cfg_interrupt_msi_sent = 1'b1;
        step();
        bus.cfg_interrupt_msi_sent = 1'b0;
    endtask

    task automatic issue_and_ack(input string tag, input logic [31:0] exp);
        int          c;
        logic [31:0] got;
        wait_int(tag, 200, c, got);
        chk(tag, got, exp);
        step();
        pulse_sent();
    endtask

    initial begin
        bus.s_irq_valid                   = 1'b0;
        bus.s_irq_index                   = '0;
        bus.cfg_interrupt_msi_enable      = 4'h1;
        bus.cfg_interrupt_msi_mmenable    = 12'd2;
        bus.cfg_interrupt_msi_mask_update = 1'b0;
        bus.cfg_interrupt_msi_data        = '0;
        bus.cfg_interrupt_msi_sent        = 1'b0;
        bus.cfg_interrupt_msi_fail        = 1'b0;
        cfg_holdoff                       = '0;

        // Reset state
        repeat (3) step();
        chk("rst_ready", 32'(bus.s_irq_ready), 32'd0);
        chk("rst_int", bus.cfg_interrupt_msi_int, 32'd0);
        chk("rst_pend", bus.cfg_interrupt_msi_pending_status, 32'd0);
        chk("rst_de", 32'(bus.cfg_interrupt_msi_pending_status_data_enable), 32'd0);
        chk("rst_stat", 32'(stat_fail_count), 32'd0);
        chk("consts", 32'({bus.cfg_interrupt_msi_select, bus.cfg_interrupt_msi_pending_status_function_num,
                           bus.cfg_interrupt_msi_attr, bus.cfg_interrupt_msi_tph_present,
                           bus.cfg_interrupt_msi_tph_type, bus.cfg_interrupt_msi_tph_st_tag,
                           bus.cfg_interrupt_msi_function_number}), 32'd0);
        pcie_rst = 1'b0;
        step();
        chk("ready", 32'(bus.s_irq_ready), 32'd1);

        // Fold 13 onto 4 granted vectors -> vector 1
        send_irq(13);
        chk("fold_pend", bus.cfg_interrupt_msi_pending_status, 32'h2);
        chk("fold_de", 32'(bus.cfg_interrupt_msi_pending_status_data_enable), 32'd1);
        chk("fold_int_n1", bus.cfg_interrupt_msi_int, 32'd0);
        step();
        chk("fold_int", bus.cfg_interrupt_msi_int, 32'h2);
        step();
        chk("issue_low", bus.cfg_interrupt_msi_int, 32'd0);
        chk("issue_pend", bus.cfg_interrupt_msi_pending_status, 32'd0);
        pulse_sent();
        chk("sent_pend", bus.cfg_interrupt_msi_pending_status, 32'd0);

        // Round robin from last_issued = 1 with 3, 1, 2 pending
        bus.cfg_interrupt_msi_enable = 4'h0;
        send_irq(3);
        send_irq(1);
        send_irq(2);
        step();
        chk("dis_hold_int", bus.cfg_interrupt_msi_int, 32'd0);
        chk("dis_pend", bus.cfg_interrupt_msi_pending_status, 32'hE);
        bus.cfg_interrupt_msi_enable = 4'h1;
        issue_and_ack("rr_first", 32'h4);
        issue_and_ack("rr_second", 32'h8);
        issue_and_ack("rr_third", 32'h2);

        // Fail, backoff, timeout on vector 4
        bus.cfg_interrupt_msi_mmenable = 12'd3;
        send_irq(4);
        wait_int("fail_issue", 50, k, v);
        chk("fail_issue", v, 32'h10);
        step();
        bus.cfg_interrupt_msi_fail = 1'b1;
        step();
        bus.cfg_interrupt_msi_fail = 1'b0;
        chk("fail_pend", bus.cfg_interrupt_msi_pending_status, 32'h10);
        chk("fail_stat", 32'(stat_fail_count), 32'd1);
        wait_int("backoff", 200, k, v);
        chk("backoff_lat", 32'(k), 32'd65);
        chk("backoff_vec", v, 32'h10);
        step();
        k = 0;
        while (k < 1100 && stat_fail_count != 16'd2) begin
            step();
            k++;
        end
        chk("timeout_stat", 32'(stat_fail_count), 32'd2);
        chk("timeout_lat", 32'(k), 32'd1024);
        chk("timeout_pend", bus.cfg_interrupt_msi_pending_status, 32'h10);
        issue_and_ack("timeout_reissue", 32'h10);

        // Holdoff of 2 ticks, 4 cycles per tick
        cfg_holdoff = 16'd2;
        send_irq(0);
        issue_and_ack("hold_first", 32'h1);
        send_irq(0);
        chk("hold_pend", bus.cfg_interrupt_msi_pending_status, 32'h1);
        wait_int("hold_reissue", 50, k, v);
        chk("hold_lat_min", 32'(k >= 5), 32'd1);
        chk("hold_lat_max", 32'(k <= 8), 32'd1);
        chk("hold_vec", v, 32'h1);
        cfg_holdoff = 16'd0;
        step();
        pulse_sent();

        // Mask blocks vector 0 until cleared
        bus.cfg_interrupt_msi_mask_update = 1'b1;
        bus.cfg_interrupt_msi_data        = 32'h1;
        step();
        bus.cfg_interrupt_msi_mask_update = 1'b0;
        send_irq(0);
        repeat (4) step();
        chk("mask_int", bus.cfg_interrupt_msi_int, 32'd0);
        chk("mask_pend", bus.cfg_interrupt_msi_pending_status, 32'h1);
        bus.cfg_interrupt_msi_mask_update = 1'b1;
        bus.cfg_interrupt_msi_data        = 32'h0;
        step();
        bus.cfg_interrupt_msi_mask_update = 1'b0;
        chk("unmask_n1", bus.cfg_interrupt_msi_int, 32'd0);
        step();
        chk("unmask_int", bus.cfg_interrupt_msi_int, 32'h1);
        step();
        pulse_sent();

        // Reset while in WAIT, later sent ignored
        send_irq(2);
        wait_int("rstw_issue", 50, k, v);
        chk("rstw_issue", v, 32'h4);
        step();
        send_irq(5);
        chk("rstw_pend", bus.cfg_interrupt_msi_pending_status, 32'h20);
        pcie_rst = 1'b1;
        step();
        chk("rstw_ready", 32'(bus.s_irq_ready), 32'd0);
        chk("rstw_pend0", bus.cfg_interrupt_msi_pending_status, 32'd0);
        chk("rstw_stat", 32'(stat_fail_count), 32'd0);
        pcie_rst = 1'b0;
        step();
        pulse_sent();
        step();
        chk("rstw_int", bus.cfg_interrupt_msi_int, 32'd0);
        chk("rstw_pend1", bus.cfg_interrupt_msi_pending_status, 32'd0);
        chk("rstw_ready1", 32'(bus.s_irq_ready), 32'd1);
        send_irq(3);
        step();
        chk("post_rst_int", bus.cfg_interrupt_msi_int, 32'h8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
